// File: rtl/beamscaler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : beamscaler_pkg
// Description : Shared types and constants for the beam scaler readout path.
//               Holds the readout FSM state type and the frame header magic
//               byte.
// Revision    : 1.0 - initial release
// ============================================================================
package beamscaler_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    HEADER = 3'd2,
    READ   = 3'd3,
    DRAIN  = 3'd4
  } readout_state_t;

  localparam logic [7:0] SCALER_HDR_MAGIC = 8'hBE;

endpackage
`default_nettype wire

// File: rtl/readout_fifo.sv
`default_nettype none
// ============================================================================
// Module      : readout_fifo
// Description : Show-ahead synchronous FIFO with an occupancy count output.
//               Push and pop may occur in the same cycle, including when the
//               FIFO is full. pop_data always shows the head entry.
// Ports       : clk, rst (async, active-high)
//               push/push_data  - write side
//               pop/pop_data    - read side (head entry, valid when !empty)
//               empty, full, count - status
// Revision    : 1.0 - initial release
// ============================================================================
module readout_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          pop_data,
  output logic                      empty,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/beamscaler_readout.sv
`default_nettype none
// ============================================================================
// Module      : beamscaler_readout
// Description : On each scaler update-done pulse, reads NWORDS words from the
//               scaler RAM read bank and streams a header plus the data words
//               on a 32-bit valid/ready interface. Done pulses arriving while
//               a frame is in progress are counted and flagged in the next
//               header.
// Ports       : wb_clk_i, wb_rst_i (async, active-high)
//               done_i, write_bank_i              - scaler block status
//               scal_rd_o, scal_adr_o, scal_dat_i - scaler RAM read port
//               m_tdata_o, m_tvalid_o, m_tready_i, m_tlast_o - output stream
//               busy_o, overrun_cnt_o             - status
// Revision    : 1.0 - initial release
// ============================================================================
module beamscaler_readout
  import beamscaler_pkg::*;
#(
  parameter int NWORDS      = 96,
  parameter int START_DELAY = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int RD_LATENCY  = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        done_i,
  input  logic        write_bank_i,
  output logic        scal_rd_o,
  output logic [7:0]  scal_adr_o,
  input  logic [31:0] scal_dat_i,
  output logic [31:0] m_tdata_o,
  output logic        m_tvalid_o,
  input  logic        m_tready_i,
  output logic        m_tlast_o,
  output logic        busy_o,
  output logic [15:0] overrun_cnt_o
);

  localparam int         CW        = $clog2(FIFO_DEPTH) + 1;
  localparam int         IW        = CW + 1;
  localparam logic [8:0] LAST_ADDR = 9'(NWORDS - 1);

  readout_state_t state, state_nxt;

  logic [7:0]            delay_cnt;
  logic                  bank;
  logic                  ovr_sticky;
  logic [15:0]           seq;
  logic [8:0]            addr;
  logic                  rd_last;
  logic [RD_LATENCY-1:0] vld_pipe;
  logic [RD_LATENCY-1:0] tag_pipe;
  logic [IW-1:0]         inflight;
  logic                  credit_ok;
  logic                  hdr_push;
  logic                  rd_issue;
  logic [31:0]           header;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic [32:0]           fifo_din;
  logic [32:0]           fifo_dout;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [CW-1:0]         fifo_count;

  // The read currently on the RAM port is not yet in the valid pipe, so it is
  // counted here too; otherwise one extra word could land in a full FIFO.
  always_comb begin
    inflight = {{CW{1'b0}}, scal_rd_o};
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + {{CW{1'b0}}, vld_pipe[i]};
    end
  end

  assign credit_ok = (({1'b0, fifo_count} + inflight) < IW'(FIFO_DEPTH));
  assign header    = {SCALER_HDR_MAGIC, 6'b0, ovr_sticky, bank, seq};

  // ---------------- FSM: state register ----------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (done_i)                            state_nxt = WAIT;
      WAIT:    if (delay_cnt == 8'd0)                 state_nxt = HEADER;
      HEADER:  if (!fifo_full)                        state_nxt = READ;
      READ:    if (credit_ok && (addr == LAST_ADDR))  state_nxt = DRAIN;
      DRAIN:   if (inflight == '0)                    state_nxt = IDLE;
      default:                                        state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy_o   = (state != IDLE);
    hdr_push = 1'b0;
    rd_issue = 1'b0;
    case (state)
      HEADER:  hdr_push = !fifo_full;
      READ:    rd_issue = credit_ok;
      default: ;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      delay_cnt     <= '0;
      bank          <= 1'b0;
      ovr_sticky    <= 1'b0;
      seq           <= '0;
      addr          <= '0;
      scal_rd_o     <= 1'b0;
      scal_adr_o    <= '0;
      rd_last       <= 1'b0;
      vld_pipe      <= '0;
      tag_pipe      <= '0;
      overrun_cnt_o <= '0;
    end else begin
      if ((state == IDLE) && done_i) begin
        delay_cnt <= 8'(START_DELAY - 1);
      end else if ((state == WAIT) && (delay_cnt != 8'd0)) begin
        delay_cnt <= delay_cnt - 8'd1;
      end

      if ((state == WAIT) && (delay_cnt == 8'd0)) begin
        bank <= ~write_bank_i;
      end

      if (hdr_push) begin
        addr <= '0;
      end else if (rd_issue) begin
        addr <= addr + 9'd1;
      end

      scal_rd_o <= rd_issue;
      rd_last   <= rd_issue && (addr == LAST_ADDR);
      if (rd_issue) begin
        scal_adr_o <= addr[7:0];
      end

      vld_pipe[0] <= scal_rd_o;
      tag_pipe[0] <= rd_last;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end

      if ((state == DRAIN) && (inflight == '0)) begin
        seq <= seq + 16'd1;
      end

      // A done pulse coinciding with the header push is not in that header,
      // so the set must win over the clear.
      if (hdr_push) ovr_sticky <= 1'b0;
      if (done_i && busy_o) begin
        ovr_sticky <= 1'b1;
        if (overrun_cnt_o != 16'hFFFF) begin
          overrun_cnt_o <= overrun_cnt_o + 16'd1;
        end
      end
    end
  end

  // The header and RAM data never collide: DRAIN empties the read pipe
  // before the next HEADER state can be reached.
  assign fifo_push = hdr_push | vld_pipe[RD_LATENCY-1];
  assign fifo_din  = hdr_push ? {1'b0, header}
                              : {tag_pipe[RD_LATENCY-1], scal_dat_i};
  assign fifo_pop  = m_tready_i;

  readout_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .push      (fifo_push),
    .push_data (fifo_din),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign m_tvalid_o = !fifo_empty;
  assign m_tdata_o  = fifo_dout[31:0];
  assign m_tlast_o  = !fifo_empty && fifo_dout[32];

endmodule
`default_nettype wire

// File: tb/tb_beamscaler_readout.sv
`default_nettype none
// ============================================================================
// Module      : tb_beamscaler_readout
// Description : Self-checking bench for beamscaler_readout. Models the scaler
//               RAM, collects the output stream and compares whole frames
//               against frames built from the header/data rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_beamscaler_readout;

    logic        clk = 1'b0;
    logic        rst;
    logic        done;
    logic        write_bank;
    logic        scal_rd;
    logic [7:0]  scal_adr;
    logic [31:0] scal_dat;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        busy;
    logic [15:0] overrun_cnt;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    beamscaler_readout dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .done_i        (done),
        .write_bank_i  (write_bank),
        .scal_rd_o     (scal_rd),
        .scal_adr_o    (scal_adr),
        .scal_dat_i    (scal_dat),
        .m_tdata_o     (m_tdata),
        .m_tvalid_o    (m_tvalid),
        .m_tready_i    (m_tready),
        .m_tlast_o     (m_tlast),
        .busy_o        (busy),
        .overrun_cnt_o (overrun_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- RAM model: data two cycles after the read ----------------
    logic [7:0]  salt;
    logic [31:0] ram_p1;

    function automatic logic [31:0] ram_word(input logic [7:0] a, input logic [7:0] s);
        return {a, ~a, a ^ 8'hA5, s};
    endfunction

    always @(posedge clk) begin
        ram_p1   <= scal_rd ? ram_word(scal_adr, salt) : 32'hDEAD_BEEF;
        scal_dat <= ram_p1;
    end

    // ---------------- stream monitor ----------------
    logic [32:0] q[$];
    int          issued;
    int          popped;
    logic        stall_prev;
    logic [32:0] stall_word;

    // Sampled on the falling edge; a handshake seen here completes on the next
    // rising edge because inputs only change just after rising edges.
    always @(negedge clk) begin
        if (rst) begin
            issued     <= 0;
            popped     <= 0;
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", m_tvalid, 1'b1);
                chk("stall_stable", {m_tlast, m_tdata}, stall_word);
            end
            if (scal_rd) begin
                chk("credit", ((issued - popped) < 4), 1'b1);
                issued <= issued + 1;
            end
            if (m_tvalid && m_tready) begin
                q.push_back({m_tlast, m_tdata});
                if (m_tdata[31:24] != 8'hBE) popped <= popped + 1;
            end
            stall_prev <= m_tvalid && !m_tready;
            stall_word <= {m_tlast, m_tdata};
        end
    end

    logic [15:0] exp_ovr_cnt;

    // Runs one frame and compares the full 97-word stream against the frame
    // built from the header layout and the RAM model.
    task automatic run_frame(input logic wb, input bit bp, input int extra_at,
                             input bit toggle, input logic [15:0] exp_seq,
                             input logic exp_ovr);
        int cyc;
        logic [32:0] exp_w;
        salt       = 8'($urandom);
        write_bank = wb;
        q.delete();
        @(posedge clk); #1 done = 1'b1;
        @(posedge clk); #1 done = 1'b0;
        cyc = 0;
        while (q.size() < 97 && cyc < 4000) begin
            m_tready = bp ? ($urandom_range(0, 99) >= 30) : 1'b1;
            done     = (cyc == extra_at);
            if (cyc == extra_at && exp_ovr_cnt != 16'hFFFF) exp_ovr_cnt++;
            if (toggle && cyc == 20) write_bank = ~write_bank;
            @(posedge clk); #1;
            cyc++;
        end
        done     = 1'b0;
        m_tready = 1'b1;
        chk("frame_len", q.size(), 97);
        if (q.size() == 97) begin
            for (int i = 0; i < 97; i++) begin
                if (i == 0) exp_w = {1'b0, 8'hBE, 6'b0, exp_ovr, ~wb, exp_seq};
                else        exp_w = {(i == 96), ram_word(8'(i - 1), salt)};
                chk("frame_word", q[i], exp_w);
            end
        end
        cyc = 0;
        while (busy && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("busy_low", busy, 1'b0);
        chk("overrun_cnt", overrun_cnt, exp_ovr_cnt);
    endtask

    initial begin
        int   cyc;
        int   nhdr;
        bit   seen;
        rst         = 1'b1;
        done        = 1'b0;
        write_bank  = 1'b0;
        m_tready    = 1'b1;
        salt        = 8'h00;
        exp_ovr_cnt = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", m_tvalid, 1'b0);
        chk("rst_last", m_tlast, 1'b0);
        chk("rst_rd", scal_rd, 1'b0);
        chk("rst_adr", scal_adr, 8'h00);
        chk("rst_ovr", overrun_cnt, 16'h0000);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Plain frame, bank 1 read.
        run_frame(1'b0, 1'b0, -1, 1'b0, 16'd0, 1'b0);
        // Backpressure, write bank 1 at expiry, bank toggled mid-frame.
        run_frame(1'b1, 1'b1, -1, 1'b1, 16'd1, 1'b0);
        // Overrun during READ; this frame is unaffected.
        run_frame(1'b0, 1'b1, 30, 1'b0, 16'd2, 1'b0);
        // The next header carries the sticky flag, the one after does not.
        run_frame(1'b1, 1'b0, -1, 1'b0, 16'd3, 1'b1);
        run_frame(1'b0, 1'b1, -1, 1'b0, 16'd4, 1'b0);

        // Asynchronous reset while stalled in READ.
        salt       = 8'($urandom);
        m_tready   = 1'b0;
        write_bank = 1'b0;
        @(posedge clk); #1 done = 1'b1;
        @(posedge clk); #1 done = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("pre_rst_busy", busy, 1'b1);
        chk("pre_rst_valid", m_tvalid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_valid", m_tvalid, 1'b0);
        chk("arst_last", m_tlast, 1'b0);
        chk("arst_rd", scal_rd, 1'b0);
        chk("arst_adr", scal_adr, 8'h00);
        chk("arst_ovr", overrun_cnt, 16'h0000);
        exp_ovr_cnt = 16'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_tready = 1'b1;
        q.delete();
        repeat (10) @(posedge clk);
        #1;
        chk("no_partial", q.size(), 0);
        run_frame(1'b1, 1'b0, -1, 1'b0, 16'd0, 1'b0);

        // done_i held high: every busy cycle is an overrun, so the counter
        // must reach saturation well within this many cycles.
        q.delete();
        nhdr = 0;
        done = 1'b1;
        for (int c = 0; c < 70000; c++) begin
            @(posedge clk); #1;
            while (q.size() > 0) begin
                if (q[0][31:24] == 8'hBE) nhdr++;
                void'(q.pop_front());
            end
        end
        // Release only once a header has gone out, so the running frame has
        // seen overruns after its header push.
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
            while (q.size() > 0) begin
                if (q[0][31:24] == 8'hBE) begin
                    nhdr++;
                    seen = 1'b1;
                end
                void'(q.pop_front());
            end
        end
        chk("sat_hdr_seen", seen, 1'b1);
        repeat (5) @(posedge clk);
        #1 done = 1'b0;
        cyc = 0;
        while ((busy || m_tvalid) && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("sat_idle", busy || m_tvalid, 1'b0);
        while (q.size() > 0) begin
            if (q[0][31:24] == 8'hBE) nhdr++;
            void'(q.pop_front());
        end
        chk("ovr_saturated", overrun_cnt, 16'hFFFF);
        exp_ovr_cnt = 16'hFFFF;
        run_frame(1'b0, 1'b0, 10, 1'b0, 16'(1 + nhdr), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
